red_pitaya_pfd_digitizer: RTL and testbench

//  Front end of the phase-frequency detector. Converts two 14-bit signed ADC

---
 rtl/red_pitaya_pfd_pkg.sv | 25 ++
 rtl/red_pitaya_pfd_digitizer_ch.sv | 113 +++++++++++
 rtl/red_pitaya_pfd_digitizer.sv | 69 ++++++
 tb/tb_red_pitaya_pfd_digitizer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_pfd_pkg.sv
// -----------------------------------------------------------------------------
// red_pitaya_pfd_pkg
// Shared definitions for the phase-frequency detector front end and the PFD
// integrator.
//   ADC_W               : ADC sample width (14-bit signed)
//   DIVBITS_DEF         : default prescaler ratio / edge counter width
//   GLITCHBITS_DEF      : default deglitch length / run counter width
//   sample_t            : 14-bit signed sample, also the integrator output type
//   thr_valid()         : true when the hysteresis window is well formed
// -----------------------------------------------------------------------------
package red_pitaya_pfd_pkg;

    localparam int ADC_W          = 14;
    localparam int DIVBITS_DEF    = 8;
    localparam int GLITCHBITS_DEF = 4;

    typedef logic signed [ADC_W-1:0] sample_t;

    // An inverted window (lo above hi) would make both switching conditions
    // true at once, so the comparator is frozen instead.
    function automatic logic thr_valid(input sample_t lo, input sample_t hi);
        return (lo <= hi);
    endfunction

endpackage

// File: rtl/red_pitaya_pfd_digitizer_ch.sv
// -----------------------------------------------------------------------------
// red_pitaya_pfd_digitizer_ch
// One digitizer channel: input register, hysteresis comparator with deglitch
// run counter, and an optional divide-by-2N edge prescaler.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous reset, active-high
//   dat_i       signed ADC sample
//   thr_hi_i    upper threshold (signed)
//   thr_lo_i    lower threshold (signed)
//   deglitch_i  required run length minus 1
//   div_i       prescale ratio N, 0 = bypass
//   cmp_o       comparator state (stage 2)
//   s_o         square-wave output (stage 3)
// -----------------------------------------------------------------------------
module red_pitaya_pfd_digitizer_ch
    import red_pitaya_pfd_pkg::*;
#(
    parameter int DIVBITS    = DIVBITS_DEF,
    parameter int GLITCHBITS = GLITCHBITS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic signed [ADC_W-1:0] dat_i,
    input  logic signed [ADC_W-1:0] thr_hi_i,
    input  logic signed [ADC_W-1:0] thr_lo_i,
    input  logic [GLITCHBITS-1:0] deglitch_i,
    input  logic [DIVBITS-1:0]    div_i,
    output logic                  cmp_o,
    output logic                  s_o
);

    // Stage 1
    sample_t               r_dat;
    // Stage 2
    logic [GLITCHBITS-1:0] r_run;
    logic                  r_cmp;
    // Stage 3
    logic                  r_cmp_d;
    logic [DIVBITS-1:0]    r_edge_cnt;
    logic                  r_s;

    logic                  w_thr_ok;
    logic                  w_qual;
    logic                  w_switch;
    logic [GLITCHBITS-1:0] w_run_inc;
    logic                  w_rise;
    logic [DIVBITS:0]      w_edge_inc;
    logic                  w_div_hit;

    assign w_thr_ok  = thr_valid(thr_lo_i, thr_hi_i);
    // Strict compares: a sample sitting exactly on a threshold never counts.
    assign w_qual    = r_cmp ? (r_dat < thr_lo_i) : (r_dat > thr_hi_i);
    // >= so that shrinking deglitch_i below the running count switches at once.
    assign w_switch  = w_qual && (r_run >= deglitch_i);
    assign w_run_inc = (&r_run) ? r_run : r_run + GLITCHBITS'(1);

    assign w_rise     = r_cmp & ~r_cmp_d;
    // One extra bit so the increment can never wrap before the compare.
    assign w_edge_inc = {1'b0, r_edge_cnt} + (DIVBITS+1)'(1);
    assign w_div_hit  = (w_edge_inc >= {1'b0, div_i});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dat <= '0;
        end else begin
            r_dat <= dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_run <= '0;
            r_cmp <= 1'b0;
        end else if (!w_thr_ok) begin
            r_run <= '0;
        end else if (w_switch) begin
            r_cmp <= ~r_cmp;
            r_run <= '0;
        end else if (w_qual) begin
            r_run <= w_run_inc;
        end else begin
            r_run <= '0;
        end
    end

    // In divide mode r_s is the toggle flop itself, so it moves only on a
    // counted edge and lands on the same cycle a bypassed copy of cmp would.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cmp_d    <= 1'b0;
            r_edge_cnt <= '0;
            r_s        <= 1'b0;
        end else begin
            r_cmp_d <= r_cmp;
            if (div_i == '0) begin
                r_edge_cnt <= '0;
                r_s        <= r_cmp;
            end else if (w_rise) begin
                if (w_div_hit) begin
                    r_edge_cnt <= '0;
                    r_s        <= ~r_s;
                end else begin
                    r_edge_cnt <= w_edge_inc[DIVBITS-1:0];
                end
            end
        end
    end

    assign cmp_o = r_cmp;
    assign s_o   = r_s;

endmodule

// File: rtl/red_pitaya_pfd_digitizer.sv
// -----------------------------------------------------------------------------
// red_pitaya_pfd_digitizer
// Converts two signed ADC streams into square waves for the PFD s1/s2 inputs.
// Both channels share thresholds and deglitch length; prescalers are separate.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   dat_a_i, dat_b_i        signed channel samples
//   thr_hi_i, thr_lo_i      shared hysteresis thresholds (signed)
//   deglitch_i              shared run length minus 1
//   div_a_i, div_b_i        per-channel prescale ratio, 0 = bypass
//   cmp_a_o, cmp_b_o        comparator states (debug)
//   s1_o, s2_o              square waves to the PFD
// -----------------------------------------------------------------------------
module red_pitaya_pfd_digitizer
    import red_pitaya_pfd_pkg::*;
#(
    parameter int DIVBITS    = DIVBITS_DEF,
    parameter int GLITCHBITS = GLITCHBITS_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic signed [ADC_W-1:0] dat_a_i,
    input  logic signed [ADC_W-1:0] dat_b_i,
    input  logic signed [ADC_W-1:0] thr_hi_i,
    input  logic signed [ADC_W-1:0] thr_lo_i,
    input  logic [GLITCHBITS-1:0]   deglitch_i,
    input  logic [DIVBITS-1:0]      div_a_i,
    input  logic [DIVBITS-1:0]      div_b_i,
    output logic                    cmp_a_o,
    output logic                    cmp_b_o,
    output logic                    s1_o,
    output logic                    s2_o
);

    sample_t            w_dat [2];
    logic [DIVBITS-1:0] w_div [2];
    logic               w_cmp [2];
    logic               w_s   [2];

    assign w_dat[0] = dat_a_i;
    assign w_dat[1] = dat_b_i;
    assign w_div[0] = div_a_i;
    assign w_div[1] = div_b_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            red_pitaya_pfd_digitizer_ch #(
                .DIVBITS    (DIVBITS),
                .GLITCHBITS (GLITCHBITS)
            ) u_ch (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .dat_i      (w_dat[gi]),
                .thr_hi_i   (thr_hi_i),
                .thr_lo_i   (thr_lo_i),
                .deglitch_i (deglitch_i),
                .div_i      (w_div[gi]),
                .cmp_o      (w_cmp[gi]),
                .s_o        (w_s[gi])
            );
        end
    endgenerate

    assign cmp_a_o = w_cmp[0];
    assign cmp_b_o = w_cmp[1];
    assign s1_o    = w_s[0];
    assign s2_o    = w_s[1];

endmodule

// File: tb/tb_red_pitaya_pfd_digitizer.sv
module tb_red_pitaya_pfd_digitizer;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [13:0] dat_a, dat_b, thr_hi, thr_lo;
    logic [3:0]        deglitch;
    logic [7:0]        div_a, div_b;
    logic              cmp_a, cmp_b, s1, s2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    red_pitaya_pfd_digitizer dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .dat_a_i    (dat_a),
        .dat_b_i    (dat_b),
        .thr_hi_i   (thr_hi),
        .thr_lo_i   (thr_lo),
        .deglitch_i (deglitch),
        .div_a_i    (div_a),
        .div_b_i    (div_b),
        .cmp_a_o    (cmp_a),
        .cmp_b_o    (cmp_b),
        .s1_o       (s1),
        .s2_o       (s2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive one sample pair, then sample outputs 1 time unit after the edge.
    task automatic step(input int a, input int b);
        dat_a = 14'(a);
        dat_b = 14'(b);
        @(posedge clk);
        #1;
    endtask

    function automatic int sq(input int t, input int per, input int hi_len);
        return ((t % per) < hi_len) ? 1000 : -1000;
    endfunction

    initial begin
        int rise_i, fall_i, tog, smis, hi_cnt, first_rise, last_rise, rises;
        int rises_b, v;
        logic pc, ps, ps2;

        rst = 1'b1; dat_a = '0; dat_b = '0;
        thr_hi = 14'sd100; thr_lo = -14'sd100;
        deglitch = 4'd0; div_a = 8'd0; div_b = 8'd0;

        // 1. Reset with random data
        for (int i = 0; i < 5; i++) begin
            step(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
            chk($sformatf("reset_outs_%0d", i), int'({cmp_a, cmp_b, s1, s2}), 0);
        end
        rst = 1'b0;
        step(-200, 0);
        chk("post_reset_outs", int'({cmp_a, cmp_b, s1, s2}), 0);

        // 2. Hysteresis ramp -200..200..-200
        rise_i = -1; fall_i = -1; tog = 0; smis = 0; pc = cmp_a;
        for (int i = 0; i < 801; i++) begin
            v = (i <= 400) ? (-200 + i) : (600 - i);
            step(v, 0);
            if (cmp_a !== pc) begin
                tog++;
                if (cmp_a) rise_i = i; else fall_i = i;
            end
            if (s1 !== pc) smis++;
            pc = cmp_a;
        end
        chk("hyst_rise_iter", rise_i, 302);
        chk("hyst_fall_iter", fall_i, 702);
        chk("hyst_toggles", tog, 2);
        chk("hyst_s1_delay_mismatch", smis, 0);
        chk("hyst_chB_idle", int'({cmp_b, s2}), 0);

        // 3. Deglitch
        deglitch = 4'd3; thr_hi = 14'sd0; thr_lo = 14'sd0;
        hi_cnt = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin step(500, 0);  hi_cnt += int'(cmp_a); end
            for (int i = 0; i < 3; i++) begin step(-500, 0); hi_cnt += int'(cmp_a); end
        end
        for (int i = 0; i < 4; i++) begin step(-500, 0); hi_cnt += int'(cmp_a); end
        chk("deglitch_short_pulses", hi_cnt, 0);
        rise_i = -1; fall_i = -1; pc = cmp_a;
        for (int i = 0; i < 10; i++) begin
            step((i < 4) ? 500 : -500, 0);
            if (cmp_a && !pc) rise_i = i;
            if (!cmp_a && pc) fall_i = i;
            pc = cmp_a;
        end
        chk("deglitch_rise_iter", rise_i, 4);
        chk("deglitch_fall_iter", fall_i, 8);
        // Shrinking deglitch below the running count
        deglitch = 4'd15;
        for (int i = 0; i < 6; i++) step(500, 0);
        chk("deglitch_long_hold", int'(cmp_a), 0);
        deglitch = 4'd2;
        step(500, 0);
        chk("deglitch_shrink_switch", int'(cmp_a), 1);
        deglitch = 4'd0;
        for (int i = 0; i < 4; i++) step(-500, 0);
        chk("deglitch_restore_low", int'(cmp_a), 0);

        // 4. Prescaler, div_a=5, A period 20
        div_a = 8'd5;
        for (int t = 0; t < 300; t++) step(sq(t, 20, 10), 0);
        hi_cnt = 0; tog = 0; rises = 0; first_rise = -1; last_rise = -1; ps = s1;
        for (int t = 300; t < 1100; t++) begin
            step(sq(t, 20, 10), 0);
            hi_cnt += int'(s1);
            if (s1 !== ps) tog++;
            if (s1 && !ps) begin
                rises++;
                if (first_rise < 0) first_rise = t;
                last_rise = t;
            end
            ps = s1;
        end
        chk("presc_high_cycles", hi_cnt, 400);
        chk("presc_toggles", tog, 8);
        chk("presc_rises", rises, 4);
        chk("presc_rise_span", last_rise - first_rise, 600);
        div_a = 8'd0;
        for (int t = 1100; t < 1105; t++) step(sq(t, 20, 10), 0);
        smis = 0; tog = 0; pc = cmp_a;
        for (int t = 1105; t < 1205; t++) begin
            step(sq(t, 20, 10), 0);
            if (s1 !== pc) smis++;
            if (cmp_a !== pc) tog++;
            pc = cmp_a;
        end
        chk("bypass_s1_delay_mismatch", smis, 0);
        chk("bypass_cmp_toggles", tog, 10);

        // 5. Independence, A period 20, B period 21
        for (int t = 0; t < 40; t++) step(sq(t, 20, 10), sq(t, 21, 11));
        rises = 0; rises_b = 0; ps = s1; ps2 = s2;
        for (int t = 40; t < 4240; t++) begin
            step(sq(t, 20, 10), sq(t, 21, 11));
            if (s1 && !ps)  rises++;
            if (s2 && !ps2) rises_b++;
            ps = s1; ps2 = s2;
        end
        chk("indep_s1_edges", rises, 210);
        chk("indep_s2_edges", rises_b, 200);

        // 6. Invalid thresholds freeze the comparator
        thr_hi = 14'sd100; thr_lo = -14'sd100;
        for (int i = 0; i < 5; i++) step(1000, 1000);
        chk("inv_pre_state", int'({cmp_a, cmp_b}), 3);
        thr_hi = -14'sd50; thr_lo = 14'sd50;
        tog = 0; rises = 0; pc = cmp_a; ps = cmp_b;
        for (int t = 0; t < 200; t++) begin
            step($rtoi(8000.0 * $sin(6.2831853 * real'(t) / 40.0)),
                 $rtoi(8000.0 * $sin(6.2831853 * real'(t + 7) / 40.0)));
            if (cmp_a !== pc) tog++;
            if (cmp_b !== ps) rises++;
            pc = cmp_a; ps = cmp_b;
        end
        chk("inv_togglesA", tog, 0);
        chk("inv_togglesB", rises, 0);
        chk("inv_hold_state", int'({cmp_a, cmp_b}), 3);
        thr_hi = 14'sd100; thr_lo = -14'sd100;
        tog = 0; pc = cmp_a;
        for (int t = 200; t < 400; t++) begin
            step($rtoi(8000.0 * $sin(6.2831853 * real'(t) / 40.0)),
                 $rtoi(8000.0 * $sin(6.2831853 * real'(t + 7) / 40.0)));
            if (cmp_a !== pc) tog++;
            pc = cmp_a;
        end
        chk("restore_resumes", int'(tog >= 8), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
